// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic             x, y, d, br_nx;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell plus next-state: load on accept, shift per bit.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    x     = a_sr_q[0];
    y     = b_sr_q[0];
    d     = x ^ y ^ br_q;
    br_nx = (~x & y) | (~(x ^ y) & br_q);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = {d, res_q[WIDTH-1:1]};
        br_d   = br_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d  = {d, res_q[WIDTH-1:1]};
          bout_d  = br_nx;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_d = (a_msb_q != b_msb_q) && (d != a_msb_q);
`endif
        end
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8).
// Scoreboard of expected results, compared on each done pulse.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("diff", {24'd0, diff}, {24'd0, mon_e.diff});
        chk("bout", {31'd0, bout}, {31'd0, mon_e.bout});
        chk("latency", cyc - mon_e.acc, W);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
`endif
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] ia,
                                 input logic [W-1:0] ib,
                                 input logic ibin, input int acc);
    exp_t e;
    int   full;
    full   = int'(ia) - int'(ib) - int'(ibin);
    e.diff = W'(full);
    e.bout = (int'(ia) < int'(ib) + int'(ibin));
    e.ovf  = (ia[W-1] != ib[W-1]) && (e.diff[W-1] != ia[W-1]);
    e.acc  = acc;
    return e;
  endfunction

  task automatic drive_start(input logic [W-1:0] ia,
                             input logic [W-1:0] ib, input logic ibin);
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    if (!busy) sb.push_back(model(ia, ib, ibin, cyc + 1));
  endtask

  task automatic issue(input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic ibin);
    @(negedge clk);
    drive_start(ia, ib, ibin);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    bin   = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    rst_n = 1'b1;

    issue(8'd100, 8'd37, 1'b0);
    chk("busy_e0", {31'd0, busy}, 32'd1);
    wait_done();
    issue(8'd5, 8'd9, 1'b0);
    wait_done();
    issue(8'h00, 8'h00, 1'b1);
    wait_done();

    issue(8'hAA, 8'h55, 1'b0);
    @(negedge clk);
    drive_start(8'h01, 8'h01, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", {31'd0, busy}, 32'd1);
    wait_done();

    drive_start(8'h10, 8'h01, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    repeat (6) begin
      chk("diff_held", {24'd0, diff}, 32'h55);
      @(negedge clk);
    end
    wait_done();

    issue(8'h30, 8'h05, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_diff", {24'd0, diff}, 32'd0);
    chk("arst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("arst_ovf", {31'd0, ovf}, 32'd0);
`endif
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(8'd200, 8'd100, 1'b0);
    wait_done();
    issue(8'h80, 8'h01, 1'b0);
    wait_done();
    issue(8'h10, 8'h01, 1'b0);
    wait_done();

    for (int i = 0; i < 6; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
